// File: rtl/vga_pkg.sv
// Shared timing constants, phase encoding and coordinate type for the VGA raster generator.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {ACT, FP, SYN, BP} phase_t;

    typedef logic [9:0] coord_t;

    // True when pos lies in [start, start+len); the end is formed at 11 bits so it never wraps.
    function automatic logic in_span(input coord_t pos, input coord_t start, input coord_t len);
        logic [10:0] stop;
        stop = {1'b0, start} + {1'b0, len};
        return (pos >= start) && ({1'b0, pos} < stop);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter plus the ACT/FP/SYN/BP phase FSM.
// 'phase' and 'next_count' describe the position the axis moves to on this step;
// every phase length must be at least one.
module vga_axis_counter
    import vga_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   clr,
    input  logic   step,
    input  coord_t len_act,
    input  coord_t len_fp,
    input  coord_t len_syn,
    input  coord_t len_bp,
    output coord_t count,
    output phase_t phase,
    output logic   wrap,
    output coord_t next_count
);

    logic [10:0] end_act;
    logic [10:0] end_fp;
    logic [10:0] end_syn;
    logic [10:0] total;
    phase_t      state;

    assign end_act    = {1'b0, len_act};
    assign end_fp     = end_act + {1'b0, len_fp};
    assign end_syn    = end_fp + {1'b0, len_syn};
    assign total      = end_syn + {1'b0, len_bp};
    assign wrap       = ({1'b0, count} == (total - 11'd1));
    assign next_count = !step ? count : (wrap ? '0 : count + 10'd1);

    // Counter and phase state; clear parks the axis on its last position so the next step lands on 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= coord_t'(total - 11'd1);
            state <= BP;
        end else if (clr) begin
            count <= coord_t'(total - 11'd1);
            state <= BP;
        end else begin
            count <= next_count;
            state <= phase;
        end
    end

    // Next phase: advance when the stepped position reaches the next phase boundary.
    always_comb begin
        phase = state;
        if (step) begin
            case (state)
                ACT:     if ({1'b0, next_count} == end_act) phase = FP;
                FP:      if ({1'b0, next_count} == end_fp)  phase = SYN;
                SYN:     if ({1'b0, next_count} == end_syn) phase = BP;
                BP:      if (wrap)                          phase = ACT;
                default: phase = BP;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-enable divider, horizontal/vertical axes,
// registered pixel-stage outputs, sprite window test and frame bookkeeping.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   DIV      = 4,
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  coord_t      win_x,
    input  coord_t      win_y,
    input  coord_t      win_w,
    input  coord_t      win_h,
    output coord_t      lcd_xpos,
    output coord_t      lcd_ypos,
    output logic        vidon,
    output logic        spriteon,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank,
    output logic [15:0] frame_cnt
);

    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             clr;
    logic             v_step;
    logic             frame_tick;
    logic             act_nxt;
    logic             h_wrap;
    logic             v_wrap;
    coord_t           h_count;
    coord_t           v_count;
    coord_t           h_next;
    coord_t           v_next;
    phase_t           h_phase;
    phase_t           v_phase;
    coord_t           sx, sy, sw, sh;
    coord_t           cur_x, cur_y, cur_w, cur_h;
    logic [19:0]      unused_counts;

    assign clr           = ~en;
    assign tick          = en && (div == DIV_LAST);
    assign v_step        = tick && h_wrap;
    assign frame_tick    = v_step && v_wrap;
    assign act_nxt       = (h_phase == ACT) && (v_phase == ACT);
    assign unused_counts = {h_count, v_count};

    // Pixel-enable divider: counts 0..DIV-1 while enabled, restarts when disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (!en || tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    vga_axis_counter u_h (
        .clock      (clock),
        .reset      (reset),
        .clr        (clr),
        .step       (tick),
        .len_act    (coord_t'(H_ACTIVE)),
        .len_fp     (coord_t'(H_FP)),
        .len_syn    (coord_t'(H_SYNC)),
        .len_bp     (coord_t'(H_BP)),
        .count      (h_count),
        .phase      (h_phase),
        .wrap       (h_wrap),
        .next_count (h_next)
    );

    vga_axis_counter u_v (
        .clock      (clock),
        .reset      (reset),
        .clr        (clr),
        .step       (v_step),
        .len_act    (coord_t'(V_ACTIVE)),
        .len_fp     (coord_t'(V_FP)),
        .len_syn    (coord_t'(V_SYNC)),
        .len_bp     (coord_t'(V_BP)),
        .count      (v_count),
        .phase      (v_phase),
        .wrap       (v_wrap),
        .next_count (v_next)
    );

    // Shadow window, refreshed only on the tick that enters (0,0).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sx <= '0;
            sy <= '0;
            sw <= '0;
            sh <= '0;
        end else if (frame_tick) begin
            sx <= win_x;
            sy <= win_y;
            sw <= win_w;
            sh <= win_h;
        end
    end

    // Window seen by this tick: a frame-entering tick already uses the values being captured.
    always_comb begin
        cur_x = sx;
        cur_y = sy;
        cur_w = sw;
        cur_h = sh;
        if (frame_tick) begin
            cur_x = win_x;
            cur_y = win_y;
            cur_w = win_w;
            cur_h = win_h;
        end
    end

    // Output registers, loaded from the stepped axis state on tick; disable restores reset values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lcd_xpos    <= '0;
            lcd_ypos    <= '0;
            vidon       <= 1'b0;
            spriteon    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            frame_cnt   <= '0;
        end else if (!en) begin
            lcd_xpos    <= '0;
            lcd_ypos    <= '0;
            vidon       <= 1'b0;
            spriteon    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            line_start  <= v_step;
            frame_start <= frame_tick;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (tick) begin
                lcd_xpos <= h_next;
                lcd_ypos <= v_next;
                vidon    <= act_nxt;
                spriteon <= act_nxt && in_span(h_next, cur_x, cur_w) && in_span(v_next, cur_y, cur_h);
                hsync    <= (h_phase == SYN) ? SYNC_POL : ~SYNC_POL;
                vsync    <= (v_phase == SYN) ? SYNC_POL : ~SYNC_POL;
                vblank   <= (v_phase != ACT);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: three instances (default timing, scaled timing with
// inverted sync polarity, tiny timing with DIV=1) checked every clock against a reference
// model that derives raster position from the number of pixel ticks since enable.
module tb_vga_timing;
    import vga_pkg::*;

    localparam int N_CYC = 60000;

    // Instance 0 = D (defaults), 1 = S (scaled, SYNC_POL=1), 2 = T (tiny, DIV=1)
    localparam int P_DIV [3] = '{4, 4, 1};
    localparam int P_HA  [3] = '{640, 128, 4};
    localparam int P_HF  [3] = '{16, 8, 1};
    localparam int P_HS  [3] = '{96, 12, 2};
    localparam int P_HB  [3] = '{48, 12, 1};
    localparam int P_VA  [3] = '{480, 32, 2};
    localparam int P_VF  [3] = '{10, 2, 1};
    localparam int P_VS  [3] = '{2, 2, 1};
    localparam int P_VB  [3] = '{33, 2, 1};
    localparam bit P_POL [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vid;
        logic        spr;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic        vb;
        logic [15:0] fc;
    } obs_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   en_d, en_s, en_t;
    coord_t win_x, win_y, win_w, win_h;

    coord_t      d_x, d_y, s_x, s_y, t_x, t_y;
    logic        d_vid, d_spr, d_hs, d_vs, d_ls, d_fs, d_vb;
    logic        s_vid, s_spr, s_hs, s_vs, s_ls, s_fs, s_vb;
    logic        t_vid, t_spr, t_hs, t_vs, t_ls, t_fs, t_vb;
    logic [15:0] d_fc, s_fc, t_fc;

    obs_t act_d, act_s, act_t;
    assign act_d = {d_x, d_y, d_vid, d_spr, d_hs, d_vs, d_ls, d_fs, d_vb, d_fc};
    assign act_s = {s_x, s_y, s_vid, s_spr, s_hs, s_vs, s_ls, s_fs, s_vb, s_fc};
    assign act_t = {t_x, t_y, t_vid, t_spr, t_hs, t_vs, t_ls, t_fs, t_vb, t_fc};

    obs_t q_d[$];
    obs_t q_s[$];
    obs_t q_t[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state per instance
    int m_c  [3];
    int m_fc [3];
    int m_sx [3];
    int m_sy [3];
    int m_sw [3];
    int m_sh [3];

    always #5 clk = ~clk;

    vga_timing u_d (
        .clock(clk), .reset(rst), .en(en_d),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .lcd_xpos(d_x), .lcd_ypos(d_y), .vidon(d_vid), .spriteon(d_spr),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs),
        .vblank(d_vb), .frame_cnt(d_fc)
    );

    vga_timing #(
        .DIV(4), .H_ACTIVE(128), .H_FP(8), .H_SYNC(12), .H_BP(12),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) u_s (
        .clock(clk), .reset(rst), .en(en_s),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .lcd_xpos(s_x), .lcd_ypos(s_y), .vidon(s_vid), .spriteon(s_spr),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs),
        .vblank(s_vb), .frame_cnt(s_fc)
    );

    vga_timing #(
        .DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) u_t (
        .clock(clk), .reset(rst), .en(en_t),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .lcd_xpos(t_x), .lcd_ypos(t_y), .vidon(t_vid), .spriteon(t_spr),
        .hsync(t_hs), .vsync(t_vs), .line_start(t_ls), .frame_start(t_fs),
        .vblank(t_vb), .frame_cnt(t_fc)
    );

    // Expected outputs after the coming clock edge, from ticks elapsed since enable.
    task automatic predict(input int id, input logic rst_i, input logic en_i, output obs_t o);
        int ht, vt, t, pos, x, y;
        bit tk;
        ht = P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id];
        vt = P_VA[id] + P_VF[id] + P_VS[id] + P_VB[id];
        o = '0;
        o.hs = ~P_POL[id];
        o.vs = ~P_POL[id];
        if (rst_i) begin
            m_c[id] = 0; m_fc[id] = 0;
            m_sx[id] = 0; m_sy[id] = 0; m_sw[id] = 0; m_sh[id] = 0;
        end else if (!en_i) begin
            m_c[id] = 0;
        end else begin
            m_c[id] = m_c[id] + 1;
            tk = (m_c[id] % P_DIV[id]) == 0;
            t  = m_c[id] / P_DIV[id];
            if (t > 0) begin
                pos = (t - 1) % (ht * vt);
                x = pos % ht;
                y = pos / ht;
                if (tk && pos == 0) begin
                    m_fc[id] = (m_fc[id] + 1) % 65536;
                    m_sx[id] = int'(win_x); m_sy[id] = int'(win_y);
                    m_sw[id] = int'(win_w); m_sh[id] = int'(win_h);
                end
                o.x   = x[9:0];
                o.y   = y[9:0];
                o.vid = (x < P_HA[id]) && (y < P_VA[id]);
                o.hs  = (x >= P_HA[id] + P_HF[id] && x < P_HA[id] + P_HF[id] + P_HS[id]) ? P_POL[id] : ~P_POL[id];
                o.vs  = (y >= P_VA[id] + P_VF[id] && y < P_VA[id] + P_VF[id] + P_VS[id]) ? P_POL[id] : ~P_POL[id];
                o.spr = o.vid && x >= m_sx[id] && x < m_sx[id] + m_sw[id] &&
                        y >= m_sy[id] && y < m_sy[id] + m_sh[id];
                o.ls  = tk && (x == 0);
                o.fs  = tk && (pos == 0);
                o.vb  = (y >= P_VA[id]);
            end
        end
        o.fc = m_fc[id][15:0];
    endtask

    task automatic cmp(input string name, input obs_t a, input obs_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s outputs @%0t: got x=%0d y=%0d vid=%b spr=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d, expected x=%0d y=%0d vid=%b spr=%b hs=%b vs=%b ls=%b fs=%b vb=%b fc=%0d",
                     name, $time, a.x, a.y, a.vid, a.spr, a.hs, a.vs, a.ls, a.fs, a.vb, a.fc,
                     e.x, e.y, e.vid, e.spr, e.hs, e.vs, e.ls, e.fs, e.vb, e.fc);
        end
    endtask

    task automatic underflow(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s scoreboard empty @%0t: got no expected entry, required one per clock", name, $time);
    endtask

    obs_t last_d;

    task automatic push_all();
        obs_t e;
        predict(0, rst, en_d, e); q_d.push_back(e); last_d = e;
        predict(1, rst, en_s, e); q_s.push_back(e);
        predict(2, rst, en_t, e); q_t.push_back(e);
    endtask

    // Monitor: one output per instance per clock, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_d.size() == 0) underflow("D"); else cmp("D", act_d, q_d.pop_front());
            if (q_s.size() == 0) underflow("S"); else cmp("S", act_s, q_s.pop_front());
            if (q_t.size() == 0) underflow("T"); else cmp("T", act_t, q_t.pop_front());
        end
    end

    // Stimulus: drives inputs on the falling edge and queues the expected response.
    initial begin
        int  d_hold, s_hold, t_hold, next_win;
        bit  d_dir_done, s_done;
        d_hold = 0; s_hold = 0; t_hold = 0; next_win = 30000;
        d_dir_done = 0; s_done = 0;
        rst = 1'b1;
        en_d = 1'b1; en_s = 1'b1; en_t = 1'b1;
        win_x = 10'd32; win_y = 10'd10; win_w = 10'd64; win_h = 10'd20;
        push_all();
        for (int cyc = 1; cyc <= N_CYC; cyc++) begin
            @(negedge clk);
            if (cyc == 3) rst = 1'b0;

            if (d_hold > 0) begin
                d_hold--;
                if (d_hold == 0) en_d = 1'b1;
            end else if (!d_dir_done && !rst && last_d.vid && last_d.x == 10'd300) begin
                en_d = 1'b0; d_hold = 6; d_dir_done = 1;
            end else if (cyc > 20000 && $urandom_range(0, 4999) == 0) begin
                en_d = 1'b0; d_hold = int'($urandom_range(1, 4));
            end

            if (s_hold > 0) begin
                s_hold--;
                if (s_hold == 0) en_s = 1'b1;
            end else if (!s_done && cyc > 50000 && $urandom_range(0, 999) == 0) begin
                en_s = 1'b0; s_hold = 3; s_done = 1;
            end

            if (t_hold > 0) begin
                t_hold--;
                if (t_hold == 0) en_t = 1'b1;
            end else if (cyc > 3000 && $urandom_range(0, 149) == 0) begin
                en_t = 1'b0; t_hold = int'($urandom_range(1, 4));
            end

            if (cyc == 5000) win_x = 10'd100;
            if (cyc == next_win) begin
                win_x = ($urandom_range(0, 3) == 0) ? coord_t'($urandom_range(0, 1023)) : coord_t'($urandom_range(0, 150));
                win_y = ($urandom_range(0, 3) == 0) ? coord_t'($urandom_range(0, 1023)) : coord_t'($urandom_range(0, 30));
                win_w = ($urandom_range(0, 3) == 0) ? 10'd0 : coord_t'($urandom_range(0, 1023));
                win_h = ($urandom_range(0, 3) == 0) ? 10'd0 : coord_t'($urandom_range(0, 1023));
                next_win = cyc + int'($urandom_range(500, 4000));
            end

            if (cyc == 2000) begin
                force u_t.frame_cnt = 16'hfffd;
                m_fc[2] = 16'hfffd;
                #1;
                release u_t.frame_cnt;
            end

            push_all();
        end
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
